keypad_entry_display: RTL and testbench

Parametrised successor to the board-level keypad/display path. Scans a 4x4 hex keypad, debounces and qualifies presses with a state machine, and shifts accepted digits into an N-digit entry register. Time-multiplexes that register onto an N-digit seven-segment display with unentered digits blanked. Sits directly behind the Pmod keypad pins and the on-board anode/cathode pins; also exports key events and the entry value to downstream logic.

---
 rtl/keypad_entry_display_if.sv | 26 ++
 rtl/keypad_entry_display.sv | 255 +++++++++++++++++++++++++
 tb/tb_keypad_entry_display.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_display_if.sv
// keypad_entry_display_if
//   Key-event / entry bus between the keypad entry block and downstream logic.
//
//   Handshake: key_valid is a one-cycle pulse with no back-pressure (there is
//   no ready). key_code is valid on the pulse cycle and holds until the next
//   pulse. entry is a level that is always valid. clr is a level sampled every
//   clock by the entry block and needs no acknowledge.
//
//   Signals
//     clr        downstream -> block : synchronous clear of entry and digit count
//     key_valid  block -> downstream : one-cycle pulse per accepted key
//     key_code   block -> downstream : last accepted hex key
//     entry      block -> downstream : entry register, digit 0 in [3:0] newest
//     fsm_state  block -> downstream : qualifier state, for observation only
interface keypad_entry_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    clr;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic [4*NUM_DIGITS-1:0] entry;
    logic [1:0]              fsm_state;

    modport master (input clr, output key_valid, key_code, entry, fsm_state);
    modport slave  (output clr, input key_valid, key_code, entry, fsm_state);
endinterface

// File: rtl/keypad_entry_display.sv
// keypad_entry_display
//   Scans a 4x4 active-low hex keypad, debounces presses with a frame-based
//   qualifier FSM, shifts accepted digits into an N-digit entry register and
//   multiplexes that register onto an N-digit seven-segment display, blanking
//   digits that have not been entered yet.
//
//   Ports
//     clk, rst   clock, synchronous active-high reset
//     row_in     keypad rows, active-low, pulled up
//     col_out    keypad column drive, one-hot-low
//     an         display anodes, active-low
//     seg        cathodes {g,f,e,d,c,b,a}, active-low
//     bus        key event / entry bus (master side)
module keypad_entry_display #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 1000,
    parameter int DEBOUNCE   = 10,
    parameter int REFRESH    = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            row_in,
    output logic [3:0]            col_out,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    keypad_entry_display_if.master bus
);
    localparam int EW = 4 * NUM_DIGITS;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int NW = $clog2(NUM_DIGITS + 1);
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int XW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, PRESS_QUAL, HELD, RELEASE_QUAL} state_t;

    // ---------------- row synchroniser and column scan ----------------
    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell_cnt;
    logic [1:0]    col;
    logic          sample, frame_end;

    assign sample    = (dwell_cnt == DW'(DWELL - 1));
    assign frame_end = sample && (col == 2'd3);
    assign col_out   = ~(4'b0001 << col);

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            dwell_cnt <= '0;
            col       <= 2'd0;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
            if (sample) begin
                dwell_cnt <= '0;
                col       <= col + 2'd1;
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    // Lowest pressed row in the current column.
    logic       col_hit;
    logic [1:0] col_row;
    always_comb begin
        col_hit = 1'b0;
        col_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2[r]) begin
                col_hit = 1'b1;
                col_row = 2'(r);
            end
        end
    end

    // Columns are visited in ascending order, so the first hit of a frame is
    // the lowest col*4+row index; later hits never displace it.
    logic       acc_found;
    logic [3:0] acc_idx;
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            acc_found <= 1'b0;
            acc_idx   <= 4'd0;
        end else if (sample && col_hit && !acc_found) begin
            acc_found <= 1'b1;
            acc_idx   <= {col, col_row};
        end
    end

    logic       frm_found;
    logic [3:0] frm_idx, frm_code;
    assign frm_found = acc_found | col_hit;
    assign frm_idx   = acc_found ? acc_idx : {col, col_row};

    always_comb begin
        case (frm_idx)
            4'h0: frm_code = 4'h1;  4'h1: frm_code = 4'h4;
            4'h2: frm_code = 4'h7;  4'h3: frm_code = 4'h0;
            4'h4: frm_code = 4'h2;  4'h5: frm_code = 4'h5;
            4'h6: frm_code = 4'h8;  4'h7: frm_code = 4'hF;
            4'h8: frm_code = 4'h3;  4'h9: frm_code = 4'h6;
            4'hA: frm_code = 4'h9;  4'hB: frm_code = 4'hE;
            4'hC: frm_code = 4'hA;  4'hD: frm_code = 4'hB;
            4'hE: frm_code = 4'hC;  default: frm_code = 4'hD;
        endcase
    end

    // ---------------- qualifier FSM ----------------
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          accept;

    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (frame_end) begin
            case (state_q)
                IDLE: if (frm_found) begin
                    cand_d  = frm_code;
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE == 1) ? HELD : PRESS_QUAL;
                end
                PRESS_QUAL: begin
                    if (!frm_found) begin
                        state_d = IDLE;
                    end else if (frm_code != cand_q) begin
                        cand_d = frm_code;
                        cnt_d  = CW'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) state_d = HELD;
                    end
                end
                HELD: if (!frm_found) begin
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE == 1) ? IDLE : RELEASE_QUAL;
                end
                default: begin
                    if (frm_found) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // A press is accepted on the frame end that moves the FSM into HELD from
    // one of the press-side states (never from RELEASE_QUAL: no auto-repeat).
    always_comb begin
        accept = frame_end && (state_d == HELD) &&
                 ((state_q == IDLE) || (state_q == PRESS_QUAL));
    end

    // ---------------- entry datapath ----------------
    logic          key_valid_q;
    logic [3:0]    key_code_q;
    logic [EW-1:0] entry_q;
    logic [NW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            entry_q     <= '0;
            count_q     <= '0;
        end else begin
            key_valid_q <= accept;
            if (accept) key_code_q <= cand_d;
            // clr has priority over a coincident accept for entry/count.
            if (bus.clr) begin
                entry_q <= '0;
                count_q <= '0;
            end else if (accept) begin
                entry_q <= (entry_q << 4) | EW'(cand_d);
                if (count_q != NW'(NUM_DIGITS)) count_q <= count_q + NW'(1);
            end
        end
    end

    assign bus.key_valid = key_valid_q;
    assign bus.key_code  = key_code_q;
    assign bus.entry     = entry_q;
    assign bus.fsm_state = state_q;

    // ---------------- display multiplexer ----------------
    logic [RW-1:0]         refresh_cnt;
    logic [XW-1:0]         digit_q;
    logic [EW-1:0]         entry_shift;
    logic [NUM_DIGITS-1:0] an_d;
    logic [6:0]            seg_d;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0: hex_seg = 7'b1000000;  4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;  4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;  4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;  4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;  4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;  4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;  4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;  default: hex_seg = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_q     <= '0;
            an          <= '1;
            seg         <= 7'b1111111;
        end else begin
            if (refresh_cnt == RW'(REFRESH - 1)) begin
                refresh_cnt <= '0;
                digit_q     <= (digit_q == XW'(NUM_DIGITS - 1)) ? '0 : digit_q + XW'(1);
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
            an  <= an_d;
            seg <= seg_d;
        end
    end

    assign entry_shift = entry_q >> {digit_q, 2'b00};

    always_comb begin
        an_d  = '1;
        seg_d = 7'b1111111;
        if (32'(digit_q) < 32'(count_q)) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_q);
            seg_d = hex_seg(entry_shift[3:0]);
        end
    end
endmodule

// File: tb/tb_keypad_entry_display.sv
// tb_keypad_entry_display
//   Drives a behavioural 4x4 keypad one scan frame at a time and predicts key
//   events from frame-level rules: a key is accepted when it is the resolved
//   key of DEBOUNCE consecutive frames while the keypad is armed, and the pad
//   re-arms after DEBOUNCE consecutive empty frames.
module tb_keypad_entry_display;
    localparam int NUM_DIGITS = 4;
    localparam int DWELL      = 4;
    localparam int DEBOUNCE   = 3;
    localparam int REFRESH    = 8;
    localparam int FRAME      = 4 * DWELL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] mask = 16'h0;   // pressed keys, bit index = col*4+row

    keypad_entry_display_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    keypad_entry_display #(
        .NUM_DIGITS(NUM_DIGITS), .DWELL(DWELL), .DEBOUNCE(DEBOUNCE), .REFRESH(REFRESH)
    ) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .an(an), .seg(seg), .bus(bus)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to the driven-low column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_out[c])
                for (int r = 0; r < 4; r++)
                    if (mask[c*4+r]) row_in[r] = 1'b0;
    end

    logic [3:0] key_at [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                                4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [19:0] exp_q[$];     // {key_code, entry}
    int          exp_t_q[$];   // cycle stamp of the expected pulse
    int          hist[$];      // resolved code per frame, -1 = none
    bit          armed = 1'b1;
    logic [15:0] exp_entry = 16'h0;
    int          exp_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] hexpat(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic int pos_of(input logic [3:0] code);
        for (int i = 0; i < 16; i++) if (key_at[i] == code) return i;
        return 0;
    endfunction

    function automatic logic [15:0] key_mask(input logic [3:0] code);
        return 16'(1) << pos_of(code);
    endfunction

    function automatic int frame_result(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return int'(key_at[i]);
        return -1;
    endfunction

    // Called at the start of each frame with that frame's resolved key.
    task automatic model_frame(input int res, input bit clr_hit);
        bit same;
        hist.push_back(res);
        if (hist.size() > DEBOUNCE) void'(hist.pop_front());
        if (hist.size() == DEBOUNCE) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (armed && same && hist[0] >= 0) begin
                armed = 1'b0;
                exp_entry = {exp_entry[11:0], 4'(hist[0])};
                if (exp_count < NUM_DIGITS) exp_count++;
                if (clr_hit) begin
                    exp_entry = 16'h0;
                    exp_count = 0;
                end
                exp_q.push_back({4'(hist[0]), exp_entry});
                exp_t_q.push_back(cyc + FRAME);
            end else if (!armed && same && hist[0] < 0) begin
                armed = 1'b1;
            end
        end
    endtask

    // Must be entered on the negedge that opens a scan frame.
    task automatic run_frame(input logic [15:0] m, input bit clr_end);
        mask = m;
        model_frame(frame_result(m), clr_end);
        if (clr_end) begin
            repeat (FRAME - 1) @(negedge clk);
            bus.clr = 1'b1;
            @(negedge clk);
            bus.clr = 1'b0;
        end else begin
            repeat (FRAME) @(negedge clk);
        end
    endtask

    task automatic press(input logic [3:0] code, input int frames);
        repeat (frames) run_frame(key_mask(code), 1'b0);
    endtask

    task automatic idle(input int frames);
        repeat (frames) run_frame(16'h0, 1'b0);
    endtask

    // Watches the display for a whole number of frames with the keypad unchanged.
    task automatic check_display();
        bit seen [NUM_DIGITS];
        int blanks = 0;
        int d;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int f = 0; f < 2 * NUM_DIGITS * REFRESH / FRAME; f++) begin
            model_frame(frame_result(mask), 1'b0);
            repeat (FRAME) begin
                @(negedge clk);
                d = -1;
                for (int i = 0; i < NUM_DIGITS; i++) if (an == ~(4'b0001 << i)) d = i;
                if (an == 4'hF) begin
                    blanks++;
                    check("disp_blank_seg", seg, 7'h7F);
                end else if (d < 0) begin
                    check("disp_an_shape", an, 4'hF);
                end else begin
                    seen[d] = 1'b1;
                    check("disp_lit_digit_entered", 32'(d < exp_count), 1);
                    check("disp_seg", seg, hexpat(exp_entry[4*d +: 4]));
                end
            end
        end
        for (int i = 0; i < exp_count; i++) check("disp_digit_seen", seen[i], 1);
        check("disp_blank_present", 32'(blanks > 0), 32'(exp_count < NUM_DIGITS));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [19:0] e;
        int          t;
        if (!rst && bus.key_valid) begin
            check("pulse_expected", 32'(exp_q.size() != 0), 32'(bus.key_valid));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = exp_t_q.pop_front();
                check("key_code", bus.key_code, e[19:16]);
                check("entry", bus.entry, e[15:0]);
                check("pulse_cycle", cyc, t);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] m;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_valid", bus.key_valid, 0);
        check("rst_key_code", bus.key_code, 0);
        check("rst_entry", bus.entry, 0);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        rst = 1'b0;

        // Debounced press of 5.
        press(4'h5, 5);
        idle(3);
        check_display();

        // Bounce on 7: never accepted.
        press(4'h7, 2);
        idle(1);
        press(4'h7, 2);
        idle(3);
        check("bounce_entry", bus.entry, exp_entry);

        // Overflow past four digits.
        foreach (key_at[i]) begin
            if (i < 5) begin
                case (i)
                    0: press(4'h1, 3);
                    1: press(4'h2, 3);
                    2: press(4'h3, 3);
                    3: press(4'h4, 3);
                    default: press(4'hA, 3);
                endcase
                idle(3);
            end
        end
        check("overflow_entry", bus.entry, 16'h234A);
        check_display();

        // Long hold without repeat, then a second press.
        press(4'hF, 20);
        idle(3);
        press(4'hF, 3);
        idle(3);

        // clr on the same edge as the accept of 9.
        run_frame(key_mask(4'h9), 1'b0);
        run_frame(key_mask(4'h9), 1'b0);
        run_frame(key_mask(4'h9), 1'b1);
        idle(3);
        check("clr_key_code", bus.key_code, 4'h9);
        check_display();

        // Random presses, including simultaneous keys and short taps.
        repeat (14) begin
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m = m | (16'(1) << $urandom_range(0, 15));
            repeat ($urandom_range(1, 5)) run_frame(m, 1'b0);
            repeat ($urandom_range(0, 4)) run_frame(16'h0, 1'b0);
        end
        idle(3);
        check_display();

        // Reset part-way through qualifying D, key kept down.
        press(4'hD, 2);
        rst = 1'b1;
        hist.delete();
        armed = 1'b1;
        exp_entry = 16'h0;
        exp_count = 0;
        @(negedge clk);
        check("midrst_col_out", col_out, 4'b1110);
        check("midrst_key_valid", bus.key_valid, 0);
        check("midrst_entry", bus.entry, 0);
        rst = 1'b0;
        press(4'hD, 4);
        idle(3);

        check("missing_pulses", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
